// File: rtl/neuron_state_mem.sv
// neuron_state_mem: per-neuron state array with hardware init sweep, one registered read port and one write port.
module neuron_state_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_start,
    input  logic [DATA_W-1:0] init_value,
    output logic              init_busy,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_req_q, init_req_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rd_ok, wr_ok;

    assign rd_ok     = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
    assign wr_ok     = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
    assign ready     = state_q == RUN;
    assign init_busy = !ready;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_req_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = init_value;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH-1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            // init_start is registered first, so the sweep begins one edge after it is sampled
            init_req_d = init_start;
            if (init_req_q) begin
                state_d = INIT;
                cnt_d   = '0;
            end
            mem_we = wr_en && wr_ok;
            if (rd_en) begin
                rd_valid_d = 1'b1;
                rd_data_d  = !rd_ok ? '0 : (mem_we && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            init_req_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_req_q <= init_req_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_neuron_state_mem.sv
// tb_neuron_state_mem: directed checks of sweep, read/write, bypass, init requests and reset recovery.
module tb_neuron_state_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        init_start;
    logic [31:0] init_value;
    logic        init_busy, ready;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    int checks = 0;
    int errors = 0;

    neuron_state_mem dut (
        .clk(clk), .reset(reset), .init_start(init_start), .init_value(init_value),
        .init_busy(init_busy), .ready(ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic v);
        rd_en = 1'b1; rd_addr = a;
        tick();
        d = rd_data; v = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        logic [31:0] d;
        logic v;
        reset = 1'b0; init_value = 32'hFFFF_FFC0;
        tick(); tick();
        checks++; if (ready !== 1'b0 || init_busy !== 1'b1) begin errors++; $display("FAIL reset_ready ready=%b busy=%b want 0/1", ready, init_busy); end
        checks++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd data=%h valid=%b want 0/0", rd_data, rd_valid); end
        reset = 1'b1;
        wait_ready(n);
        checks++; if (n !== 64) begin errors++; $display("FAIL sweep_len got %0d want 64", n); end
        checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", init_busy); end
        foreach (d[i]) begin end
        rd(6'd0, d, v);
        checks++; if (d !== 32'hFFFF_FFC0 || v !== 1'b1) begin errors++; $display("FAIL sweep_rd0 got %h/%b want ffffffc0/1", d, v); end
        rd(6'd31, d, v);
        checks++; if (d !== 32'hFFFF_FFC0 || v !== 1'b1) begin errors++; $display("FAIL sweep_rd31 got %h/%b want ffffffc0/1", d, v); end
        rd(6'd63, d, v);
        checks++; if (d !== 32'hFFFF_FFC0 || v !== 1'b1) begin errors++; $display("FAIL sweep_rd63 got %h/%b want ffffffc0/1", d, v); end
    endtask

    task automatic test_back_to_back;
        wr(6'd3, 32'd5);
        wr(6'd4, 32'd9);
        rd_en = 1'b1; rd_addr = 6'd3;
        tick();
        checks++; if (rd_data !== 32'd5 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd3 got %0d/%b want 5/1", rd_data, rd_valid); end
        rd_addr = 6'd4;
        tick();
        checks++; if (rd_data !== 32'd9 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd4 got %0d/%b want 9/1", rd_data, rd_valid); end
        rd_en = 1'b0;
        tick();
        checks++; if (rd_data !== 32'd9 || rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0d/%b want 9/0", rd_data, rd_valid); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic v;
        wr(6'd7, 32'd1);
        rd_en = 1'b1; rd_addr = 6'd7; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'd42;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (rd_data !== 32'd42 || rd_valid !== 1'b1) begin errors++; $display("FAIL bypass got %0d/%b want 42/1", rd_data, rd_valid); end
        rd(6'd7, d, v);
        checks++; if (d !== 32'd42) begin errors++; $display("FAIL bypass_later got %0d want 42", d); end
        rd_en = 1'b1; rd_addr = 6'd3; wr_en = 1'b1; wr_addr = 6'd8; wr_data = 32'd88;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (rd_data !== 32'd5) begin errors++; $display("FAIL diff_addr_rd got %0d want 5", rd_data); end
        rd(6'd8, d, v);
        checks++; if (d !== 32'd88) begin errors++; $display("FAIL diff_addr_wr got %0d want 88", d); end
    endtask

    task automatic test_hold;
        logic [31:0] d;
        logic v;
        wr(6'd1, 32'd10);
        rd(6'd1, d, v);
        checks++; if (d !== 32'd10 || v !== 1'b1) begin errors++; $display("FAIL hold_rd got %0d/%b want 10/1", d, v); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rd_data !== 32'd10 || rd_valid !== 1'b0) begin errors++; $display("FAIL hold_idle%0d got %0d/%b want 10/0", i, rd_data, rd_valid); end
        end
    endtask

    task automatic test_init_during;
        int n;
        logic [31:0] d;
        logic v;
        init_value = 32'h0;
        init_start = 1'b1; rd_en = 1'b1; rd_addr = 6'd3;
        tick();
        init_start = 1'b0; rd_en = 1'b0;
        checks++; if (rd_data !== 32'd5 || rd_valid !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL init_same_cycle got %0d/%b ready=%b want 5/1/1", rd_data, rd_valid, ready); end
        tick();
        checks++; if (ready !== 1'b0 || init_busy !== 1'b1) begin errors++; $display("FAIL init_fall ready=%b busy=%b want 0/1", ready, init_busy); end
        wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'd77; rd_en = 1'b1; rd_addr = 6'd2;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_no_valid cycle %0d got %b want 0", n, rd_valid); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (n !== 64) begin errors++; $display("FAIL resweep_len got %0d want 64", n); end
        rd(6'd2, d, v);
        checks++; if (d !== 32'd0 || v !== 1'b1) begin errors++; $display("FAIL init_wr_dropped got %0d/%b want 0/1", d, v); end
        rd(6'd3, d, v);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL resweep_addr3 got %0d want 0", d); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [31:0] d;
        logic v;
        wr(6'd5, 32'd55);
        rd(6'd5, d, v);
        checks++; if (d !== 32'd55) begin errors++; $display("FAIL pre_reset_rd got %0d want 55", d); end
        init_value = 32'h1234_5678;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        rd_en = 1'b1; rd_addr = 6'd5;
        #2 reset = 1'b0;
        #1;
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'h0 || ready !== 1'b0 || init_busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset data=%h ready=%b busy=%b valid=%b want 0/0/1/0", rd_data, ready, init_busy, rd_valid); end
        tick(); tick(); tick();
        reset = 1'b1;
        wait_ready(n);
        checks++; if (n !== 64) begin errors++; $display("FAIL reset_resweep_len got %0d want 64", n); end
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            tick();
            checks++; if (rd_data !== 32'h1234_5678 || rd_valid !== 1'b1) begin errors++; $display("FAIL reset_word%0d got %h/%b want 12345678/1", i, rd_data, rd_valid); end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init_start = 1'b0; init_value = '0;
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_back_to_back();
        test_collision();
        test_hold();
        test_init_during();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_state_mem.md
# neuron_state_mem

Parametrised neuron-state memory: it holds one DATA_W-bit state word (for example a membrane potential) per neuron, for DEPTH neurons. It initialises every word to a programmable value after reset or on request, using a hardware sweep. After that it provides one registered read port and one write port. It sits between the neuron update datapath and the on-chip RAM. It replaces the single-word state RAM with an addressable, self-initialising array.

## Interface
Parameters:
- DATA_W, 32, width of one neuron state word
- DEPTH, 64, number of neurons (≥2)
- ADDR_W, $clog2(DEPTH), address width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- init_start  in  1  request a re-initialisation sweep (pulse)
- init_value  in  DATA_W  value written to every word during a sweep
- init_busy  out  1  sweep in progress
- ready  out  1  array accepts read/write requests
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read result
- rd_valid  out  1  rd_data updated this cycle
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data

## Operation
- FSM states: INIT and RUN.
- Reset asserted (reset=0) forces the following immediately:
  - state=INIT, sweep counter=0
  - init_busy=1, ready=0, rd_valid=0, rd_data=0
- RAM contents are not reset. Only the sweep defines them.
- INIT:
  - Each cycle, writes init_value to mem[counter], then increments the counter.
  - The write at counter=DEPTH-1 is the last one. The next state is RUN.
  - rd_en and wr_en are ignored. No rd_valid is produced.
  - init_start is ignored; the sweep is not restarted.
  - init_value must be held stable while init_busy=1.
- RUN:
  - ready=1, init_busy=0.
  - rd_en=1: read mem[rd_addr].
  - wr_en=1: mem[wr_addr] ← wr_data.
  - Read and write in the same cycle to the same address: write-first. rd_data returns wr_data through a bypass.
  - Read and write in the same cycle to different addresses: both are performed.
  - init_start=1: move to INIT with counter=0, next cycle. Any rd_en/wr_en in that same cycle is still serviced.
- rd_data holds its last value when no read completes. It is never cleared except by reset.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH): writes are dropped and reads return 0. In both cases rd_valid still pulses for reads.

## Timing
- Read latency is 1 cycle. A request at edge t produces rd_data/rd_valid after edge t+1, with rd_valid high for exactly that cycle.
- Back-to-back reads: one result per cycle, in order.
- A write at edge t is visible to a read issued at edge t (via bypass) and to all later reads.
- Sweep length:
  - After reset is released, ready rises after exactly DEPTH rising edges.
  - After an init_start accepted at edge t, ready falls after edge t+1 and rises after edge t+1+DEPTH.
- Reset asserted mid-sweep or mid-read:
  - Outputs go to reset values asynchronously.
  - A pending rd_valid is discarded.
  - The sweep restarts at 0 after release.
- init_busy = !ready at all times.

## Test plan
- Reset, then sweep:
  - Stimulus: DEPTH=64, init_value=32'hFFFF_FFC0, release reset.
  - Required: init_busy for 64 cycles, then ready=1.
  - Required: reading addresses 0, 31 and 63 returns 32'hFFFF_FFC0 each, one cycle after each request.
- Write then read:
  - Stimulus: write 5→addr 3 at t, write 9→addr 4 at t+1, read addr 3 at t+2, read addr 4 at t+3.
  - Required: rd_data=5 at t+3, 9 at t+4, with rd_valid high in both cycles only.
- Same-cycle collision:
  - Stimulus: mem[7]=1; in one cycle, rd_en and wr_en both to addr 7 with wr_data=42.
  - Required: next cycle rd_data=42; a later read of 7 also returns 42.
- Requests during INIT:
  - Stimulus: assert init_start with init_value=0 while in RUN; then issue wr_en to addr 2 with 77, and rd_en, during the sweep.
  - Required: no rd_valid during the sweep; after ready, addr 2 reads 0.
- Reset mid-sweep:
  - Stimulus: assert reset at sweep counter=20, release it 3 cycles later.
  - Required: rd_data=0 and ready=0 immediately; ready rises exactly 64 edges after release; all words equal init_value.
- Stalls and hold:
  - Stimulus: read addr 1 (value 10), then idle 5 cycles.
  - Required: rd_data stays 10 and rd_valid=0 during the idle cycles.
